// File: rtl/task_event_timer.sv
// Per-task periodic activation, deadline and watchdog timers with sticky event flags.
// Define TASK_EVENT_TIMER_CNT_EN to build the mrCntSleep/mrCntRun counters.
module task_event_timer #(
    parameter int NUM_TASKS = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_TASKS*32-1:0]      tev_preset,
    input  logic [NUM_TASKS*32-1:0]      wdev_preset,
    input  logic [NUM_TASKS*32-1:0]      d1ev_preset,
    input  logic [NUM_TASKS*32-1:0]      d2ev_preset,
    input  logic [NUM_TASKS*32-1:0]      tr_ctrl,
    input  logic [NUM_TASKS-1:0]         tr_we,
    input  logic                         run_valid,
    input  logic [$clog2(NUM_TASKS)-1:0] run_task,
    input  logic [NUM_TASKS-1:0]         task_done,
    output logic [NUM_TASKS*4-1:0]       cr_ev,
    output logic [NUM_TASKS*32-1:0]      cnt_sleep,
    output logic [NUM_TASKS*32-1:0]      cnt_run,
    output logic [NUM_TASKS-1:0]         task_ready,
    output logic                         irq
);
    localparam int TW = $clog2(NUM_TASKS);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_SLEEP,
        ST_ACTIVE
    } state_e;

    state_e      state_q [NUM_TASKS];
    state_e      state_d [NUM_TASKS];
    logic [31:0] ptmr_q  [NUM_TASKS];
    logic [31:0] ptmr_d  [NUM_TASKS];
    logic [31:0] dtmr_q  [NUM_TASKS];
    logic [31:0] dtmr_d  [NUM_TASKS];
    logic [31:0] wtmr_q  [NUM_TASKS];
    logic [31:0] wtmr_d  [NUM_TASKS];
    logic [3:0]  ev_q    [NUM_TASKS];
    logic [3:0]  ev_d    [NUM_TASKS];
    logic [3:0]  ev_set  [NUM_TASKS];
    logic [NUM_TASKS-1:0] f1_q, f1_d, f2_q, f2_d;
    logic        irq_q, irq_d;

    logic [31:0] tev [NUM_TASKS];
    logic [31:0] wd  [NUM_TASKS];
    logic [31:0] d1  [NUM_TASKS];
    logic [31:0] d2  [NUM_TASKS];
    logic [3:0]  mask [NUM_TASKS];
    logic [NUM_TASKS-1:0] en, kick, clr, hit;
    logic        unused_ctrl;

    assign unused_ctrl = ^tr_ctrl;

    for (genvar g = 0; g < NUM_TASKS; g++) begin : g_task
        assign tev[g]  = tev_preset[32*g +: 32];
        assign wd[g]   = wdev_preset[32*g +: 32];
        assign d1[g]   = d1ev_preset[32*g +: 32];
        assign d2[g]   = d2ev_preset[32*g +: 32];
        assign mask[g] = tr_ctrl[32*g+8 +: 4];
        assign en[g]   = tr_ctrl[32*g];
        assign kick[g] = tr_we[g] & tr_ctrl[32*g+1];
        assign clr[g]  = tr_we[g] & tr_ctrl[32*g+2];
        assign hit[g]  = run_valid && (run_task == TW'(g));
        assign cr_ev[4*g +: 4] = ev_q[g];
        assign task_ready[g]   = (state_q[g] == ST_ACTIVE);
    end

    always_comb begin
        irq_d = 1'b0;
        for (int i = 0; i < NUM_TASKS; i++) begin
            state_d[i] = state_q[i];
            ptmr_d[i]  = ptmr_q[i];
            dtmr_d[i]  = dtmr_q[i];
            wtmr_d[i]  = wtmr_q[i];
            f1_d[i]    = f1_q[i];
            f2_d[i]    = f2_q[i];
            ev_set[i]  = 4'b0;
            case (state_q[i])
                ST_OFF: begin
                    ptmr_d[i]  = 32'd0;
                    dtmr_d[i]  = 32'd0;
                    wtmr_d[i]  = 32'd0;
                    state_d[i] = ST_SLEEP;
                end
                ST_SLEEP: begin
                    ptmr_d[i] = ptmr_q[i] + 32'd1;
                    if (tev[i] != 32'd0 && ptmr_q[i] + 32'd1 >= tev[i]) begin
                        state_d[i]   = ST_ACTIVE;
                        ptmr_d[i]    = 32'd0;
                        dtmr_d[i]    = 32'd0;
                        wtmr_d[i]    = 32'd0;
                        f1_d[i]      = 1'b0;
                        f2_d[i]      = 1'b0;
                        ev_set[i][0] = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    dtmr_d[i] = dtmr_q[i] + 32'd1;
                    if (d1[i] != 32'd0 && dtmr_q[i] + 32'd1 >= d1[i] && !f1_q[i]) begin
                        ev_set[i][2] = 1'b1;
                        f1_d[i]      = 1'b1;
                    end
                    if (d2[i] != 32'd0 && dtmr_q[i] + 32'd1 >= d2[i] && !f2_q[i]) begin
                        ev_set[i][3] = 1'b1;
                        f2_d[i]      = 1'b1;
                    end
                    if (hit[i]) begin
                        wtmr_d[i] = wtmr_q[i] + 32'd1;
                        if (wd[i] != 32'd0 && wtmr_q[i] + 32'd1 >= wd[i]) begin
                            wtmr_d[i]    = 32'd0;
                            ev_set[i][1] = !kick[i];
                        end
                    end
                    if (task_done[i]) begin
                        state_d[i] = ST_SLEEP;
                        ptmr_d[i]  = 32'd0;
                    end
                end
                default: state_d[i] = ST_OFF;
            endcase
            if (kick[i]) wtmr_d[i] = 32'd0;
            // Disable overrides everything, including events raised this cycle.
            if (!en[i]) begin
                state_d[i] = ST_OFF;
                ptmr_d[i]  = 32'd0;
                dtmr_d[i]  = 32'd0;
                wtmr_d[i]  = 32'd0;
                ev_set[i]  = 4'b0;
            end
            ev_d[i] = (clr[i] ? 4'b0 : ev_q[i]) | ev_set[i];
            irq_d   = irq_d | (|(ev_q[i] & mask[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_TASKS; i++) begin
                state_q[i] <= ST_OFF;
                ptmr_q[i]  <= 32'd0;
                dtmr_q[i]  <= 32'd0;
                wtmr_q[i]  <= 32'd0;
                ev_q[i]    <= 4'b0;
            end
            f1_q  <= '0;
            f2_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_TASKS; i++) begin
                state_q[i] <= state_d[i];
                ptmr_q[i]  <= ptmr_d[i];
                dtmr_q[i]  <= dtmr_d[i];
                wtmr_q[i]  <= wtmr_d[i];
                ev_q[i]    <= ev_d[i];
            end
            f1_q  <= f1_d;
            f2_q  <= f2_d;
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;

`ifdef TASK_EVENT_TIMER_CNT_EN
    logic [31:0] cnt_sleep_q [NUM_TASKS];
    logic [31:0] cnt_sleep_d [NUM_TASKS];
    logic [31:0] cnt_run_q   [NUM_TASKS];
    logic [31:0] cnt_run_d   [NUM_TASKS];

    // Saturating counters; CLR wins over a same-cycle increment.
    always_comb begin
        for (int i = 0; i < NUM_TASKS; i++) begin
            cnt_sleep_d[i] = cnt_sleep_q[i];
            cnt_run_d[i]   = cnt_run_q[i];
            if (clr[i]) begin
                cnt_sleep_d[i] = 32'd0;
                cnt_run_d[i]   = 32'd0;
            end else begin
                if (state_q[i] == ST_SLEEP && cnt_sleep_q[i] != '1)
                    cnt_sleep_d[i] = cnt_sleep_q[i] + 32'd1;
                if (hit[i] && cnt_run_q[i] != '1)
                    cnt_run_d[i] = cnt_run_q[i] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_TASKS; i++) begin
            if (!reset) begin
                cnt_sleep_q[i] <= 32'd0;
                cnt_run_q[i]   <= 32'd0;
            end else begin
                cnt_sleep_q[i] <= cnt_sleep_d[i];
                cnt_run_q[i]   <= cnt_run_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_TASKS; g++) begin : g_cnt
        assign cnt_sleep[32*g +: 32] = cnt_sleep_q[g];
        assign cnt_run[32*g +: 32]   = cnt_run_q[g];
    end
`else
    assign cnt_sleep = '0;
    assign cnt_run   = '0;
`endif

endmodule
